// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register file's single write port.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (requester 0 wins).
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  output logic          q1_hit,
  output logic          q2_hit
);

  logic grant0;
  logic grant1;
  logic stage_we;

`ifdef WB_ARB_ROUND_ROBIN_EN
  typedef enum logic {PRIO_REQ0, PRIO_REQ1} prio_t;

  prio_t prio;
  logic  contended;

  assign contended = req0_valid && req1_valid && !rst;

  // The pointer names the winner of the next contended cycle and flips only when contention occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= PRIO_REQ0;
    end else if (contended) begin
      prio <= (prio == PRIO_REQ0) ? PRIO_REQ1 : PRIO_REQ0;
    end
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (contended) begin
        grant0 = (prio == PRIO_REQ0);
        grant1 = (prio == PRIO_REQ1);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end
`else
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
    end
  end
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_we <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else if (grant0) begin
      stage_we <= (req0_addr != '0);
      rf_addr  <= req0_addr;
      rf_wdata <= req0_data;
    end else if (grant1) begin
      stage_we <= (req1_addr != '0);
      rf_addr  <= req1_addr;
      rf_wdata <= req1_data;
    end else begin
      stage_we <= 1'b0;
    end
  end

  // Masking with rst keeps a staged write from landing on the edge that performs the reset.
  assign rf_we  = stage_we && !rst;
  assign q1_hit = rf_we && (q1_addr == rf_addr);
  assign q2_hit = rf_we && (q2_addr == rf_addr);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table plus randomized run against a reference model.
// Expectations follow WB_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [4:0]  q1_addr, q2_addr;
  logic        q1_hit, q2_hit;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_hit(q1_hit), .q2_hit(q2_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        r0;
    logic        r1;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        h1;
    logic        h2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] q1, input logic [4:0] q2,
                              input logic r0, input logic r1, input logic we, input logic [4:0] addr,
                              input logic [31:0] data, input logic h1, input logic h2);
    vec_t v;
    v.rst = r;  v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.q1 = q1;  v.q2 = q2; v.r0 = r0; v.r1 = r1; v.we = we; v.addr = addr; v.data = data;
    v.h1 = h1;  v.h2 = h2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic r0, input logic r1, input logic we,
                           input logic [4:0] addr, input logic [31:0] data, input logic h1, input logic h2);
    check({tag, ".req0_ready"}, {31'd0, req0_ready}, {31'd0, r0});
    check({tag, ".req1_ready"}, {31'd0, req1_ready}, {31'd0, r1});
    check({tag, ".rf_we"},      {31'd0, rf_we},      {31'd0, we});
    check({tag, ".rf_addr"},    {27'd0, rf_addr},    {27'd0, addr});
    check({tag, ".rf_wdata"},   rf_wdata,            data);
    check({tag, ".q1_hit"},     {31'd0, q1_hit},     {31'd0, h1});
    check({tag, ".q2_hit"},     {31'd0, q2_hit},     {31'd0, h2});
  endtask

  // Reference model state: the write staged for the register file and the last contended winner.
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_last;
  logic        e0, e1, ew, g0_prev, g1_prev;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h2;
    q1_addr = '0; q2_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Directed sequence, one row per cycle; rf_* columns show the previous row's transfer.
    tbl.push_back(mk(0, 1, 17, 32'h3,   0, 0, 0,            17, 0,  1, 0, 0, 0,  32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0,  0,       0, 0, 0,            17, 18, 0, 0, 1, 17, 32'h3,        1, 0));
    tbl.push_back(mk(0, 0, 0,  0,       1, 0, 32'hDEADBEEF, 0,  17, 0, 1, 0, 17, 32'h3,        0, 0));
    tbl.push_back(mk(0, 1, 18, 32'h1234, 0, 0, 0,           0,  0,  1, 0, 0, 0,  32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0,       0, 0, 0,            18, 19, 0, 0, 1, 18, 32'h1234,     1, 0));
    tbl.push_back(mk(0, 0, 0,  0,       0, 0, 0,            18, 19, 0, 0, 0, 18, 32'h1234,     0, 0));
`ifdef WB_ARB_ROUND_ROBIN_EN
    tbl.push_back(mk(0, 1, 5, 32'h55, 1, 6, 32'h66, 5, 6, 1, 0, 0, 18, 32'h1234, 0, 0));
    tbl.push_back(mk(0, 1, 5, 32'h55, 1, 6, 32'h66, 5, 6, 0, 1, 1, 5,  32'h55,   1, 0));
    tbl.push_back(mk(0, 1, 5, 32'h55, 1, 6, 32'h66, 5, 6, 1, 0, 1, 6,  32'h66,   0, 1));
    tbl.push_back(mk(0, 1, 5, 32'h55, 1, 6, 32'h66, 5, 6, 0, 1, 1, 5,  32'h55,   1, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      5, 6, 0, 0, 1, 6,  32'h66,   0, 1));
    tbl.push_back(mk(0, 1, 9, 32'h99, 0, 0, 0,      9, 0, 1, 0, 0, 6,  32'h66,   0, 0));
`else
    tbl.push_back(mk(0, 1, 5, 32'h55, 1, 6, 32'h66, 5, 6, 1, 0, 0, 18, 32'h1234, 0, 0));
    tbl.push_back(mk(0, 1, 5, 32'h55, 1, 6, 32'h66, 5, 6, 1, 0, 1, 5,  32'h55,   1, 0));
    tbl.push_back(mk(0, 1, 5, 32'h55, 1, 6, 32'h66, 5, 6, 1, 0, 1, 5,  32'h55,   1, 0));
    tbl.push_back(mk(0, 1, 5, 32'h55, 1, 6, 32'h66, 5, 6, 1, 0, 1, 5,  32'h55,   1, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      5, 6, 0, 0, 1, 5,  32'h55,   1, 0));
    tbl.push_back(mk(0, 1, 9, 32'h99, 0, 0, 0,      9, 0, 1, 0, 0, 5,  32'h55,   0, 0));
`endif
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      9, 0, 0, 0, 0, 9,  32'h99,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      9, 0, 0, 0, 0, 0,  32'h0,    0, 0));
    tbl.push_back(mk(0, 1, 3, 32'h33, 1, 4, 32'h44, 3, 4, 1, 0, 0, 0,  32'h0,    0, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
      q1_addr = tbl[i].q1; q2_addr = tbl[i].q2;
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].we, tbl[i].addr, tbl[i].data,
                tbl[i].h1, tbl[i].h2);
      @(posedge clk);
      #1;
    end

    // Randomized run, starting from a clean reset so the model state is known.
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1;
    m_we = 1'b0; m_addr = '0; m_data = '0; m_last = 1;
    g0_prev = 1'b1; g1_prev = 1'b1;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!(req0_valid && !g0_prev)) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr  = 5'($urandom_range(0, 7));
        req0_data  = $urandom;
      end
      if (!(req1_valid && !g1_prev)) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr  = 5'($urandom_range(0, 7));
        req1_data  = $urandom;
      end
      q1_addr = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom_range(0, 7));
      q2_addr = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom_range(0, 7));

      e0 = 1'b0; e1 = 1'b0;
      if (!rst) begin
        if (req0_valid && req1_valid) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
          if (m_last == 1) e0 = 1'b1; else e1 = 1'b1;
`else
          e0 = 1'b1;
`endif
        end else begin
          e0 = req0_valid;
          e1 = req1_valid;
        end
      end
      ew = m_we && !rst;
      #1;
      check_all($sformatf("rnd%0d", c), e0, e1, ew, m_addr, m_data,
                ew && (q1_addr == m_addr), ew && (q2_addr == m_addr));

      if (rst) begin
        m_we = 1'b0; m_addr = '0; m_data = '0; m_last = 1;
      end else if (e0 || e1) begin
        m_addr = e0 ? req0_addr : req1_addr;
        m_data = e0 ? req0_data : req1_data;
        m_we   = (m_addr != 0);
        if (req0_valid && req1_valid) m_last = e0 ? 0 : 1;
      end else begin
        m_we = 1'b0;
      end
      g0_prev = e0;
      g1_prev = e1;
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters: requester 0 is the ALU/main pipeline writeback, requester 1 is the multi-cycle multiply/divide unit. Each requester uses a valid/ready handshake. One request is granted per cycle, staged in an output register, and driven onto the register file's write-enable, destination-address and write-data inputs one cycle later. A pending-write hit output lets decode stall on a read of a register whose write is still in flight.

## Interface
Parameters:
- `DW`, 32, data width
- `AW`, 5, register address width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `req0_valid`  in  1  requester 0 has a write
- `req0_addr`  in  AW  requester 0 destination register
- `req0_data`  in  DW  requester 0 write data
- `req0_ready`  out  1  requester 0 accepted this cycle
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`  same for requester 1
- `rf_we`  out  1  to register file write enable
- `rf_addr`  out  AW  to register file destination address
- `rf_wdata`  out  DW  to register file write data
- `q1_addr`, `q2_addr`  in  AW  decode read addresses under check
- `q1_hit`, `q2_hit`  out  1  query address matches the staged write

## Operation
- Transfer on requester n: `reqn_valid && reqn_ready` at a rising edge.
- Once `reqn_valid` is asserted, `reqn_addr` and `reqn_data` must stay stable until the transfer. Ready never depends on addr or data.
- Readies are combinational from the valids and the priority state. At most one ready is high per cycle.
- A ready is high only when its valid is high and `rst`=0.
- Single requester valid: that requester is granted.
- Both requesters valid: the arbitration policy decides (see Configuration). The loser holds and is granted in a later cycle.
- On a transfer, the staging register loads `{we, addr, data}`. `we` = (addr != 0): writes to r0 are accepted and consumed, but `rf_we` stays low.
- No transfer in a cycle: the staging register's `we` clears and `rf_addr`/`rf_wdata` hold their last values.
- `qN_hit` = `rf_we && (qN_addr == rf_addr)`. It is combinational and never high for address 0.
- The two requesters targeting the same register is legal. The writes land in grant order, and the last grant wins.
- Reset values: `rf_we`=0, `rf_addr`=0, `rf_wdata`=0, `req0_ready`=`req1_ready`=0, `q1_hit`=`q2_hit`=0. The priority pointer resets to requester 0.
- Reset mid-operation: the staged write is discarded and never reaches the register file. Requesters must re-present the request after reset.

## Timing
- Accept to `rf_we` high: 1 cycle. The register file is written at the next edge, so the data is readable on RD ports 2 edges after acceptance.
- Sustained throughput: 1 write per cycle total.
- No combinational path from `reqn_*` to `rf_*`.
- Combinational paths: `reqn_valid` to `reqn_ready`, and `qN_addr` to `qN_hit`.

## Configuration
- `WB_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration.
  - On a contended cycle, the requester not granted on the most recent contended cycle wins. The pointer updates only on contended cycles.
  - Worst-case wait is 1 cycle.
- `WB_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, requester 0 always wins.
  - Requester 1 can starve while requester 0 is continuously valid.
  - The pointer logic is absent.

## Test plan
- Reset: assert `rst` for 2 cycles with both valids high → all outputs 0 and no ready.
- Single write: `req0`={addr 17, data 0x0000_0003}, accepted at edge T → `rf_we`=1, `rf_addr`=17, `rf_wdata`=3 during cycle T+1, and `rf_we`=0 at T+2.
- r0 write: `req1`={addr 0, data 0xDEAD_BEEF} → `req1_ready`=1 and `rf_we` stays 0. A query with `q1_addr`=0 gives `q1_hit`=0.
- Contention, both valid for 4 cycles: `req0` addr 5, `req1` addr 6. With the macro defined, grants alternate 0,1,0,1. With it undefined, all grants go to 0 and `req1_ready`=0 throughout.
- Hazard: staged write to r18 with `q1_addr`=18 and `q2_addr`=19 → `q1_hit`=1, `q2_hit`=0 for exactly one cycle.
- Reset mid-flight: accept `req0` (addr 9) at edge T with `rst`=1 in cycle T+1 → `rf_we` never asserts for r9.
